// File: rtl/truth_table_checker.sv
// Purpose : on-chip response checker; takes one {EN,a,b,c,d} vector per handshake,
//           waits SETTLE cycles, compares f against a 16-entry truth table, keeps statistics.
// Latency : vector accepted at edge T, f sampled at T+SETTLE, statistics update at T+SETTLE+1;
//           one vector per SETTLE+2 cycles.
// Backpressure: vec_ready is high only in ARMED; the stimulus holds the vector until then.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             pulse: clear statistics and (re)arm
//   vec_valid/ready   vector handshake; EN,a,b,c,d carry the vector (a = index MSB)
//   f                 DUT output under test
//   done, pass        all 16 enabled indices checked / done with no errors
//   err_count         mismatches (saturating)
//   chk_count         vectors checked (saturating)
//   first_fail_*      index/EN of the first mismatch, valid flag
//   seen_mask         enabled indices checked so far
module truth_table_checker #(
   parameter logic [15:0] EXPECTED = 16'h0000,
   parameter logic        DIS_VAL  = 1'b0,
   parameter int          SETTLE   = 2,      // legal range 1..15
   parameter int          CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic             EN,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             f,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] chk_count,
   output logic             first_fail_valid,
   output logic [3:0]       first_fail_idx,
   output logic             first_fail_en,
   output logic [15:0]      seen_mask
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_SETTLING,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state, state_nxt;
   logic [4:0]       vec_q, vec_nxt;        // {EN, a, b, c, d} as accepted
   logic [3:0]       cnt_q, cnt_nxt;
   logic             f_q, f_nxt;
   logic [CNT_W-1:0] err_q, err_nxt;
   logic [CNT_W-1:0] chk_q, chk_nxt;
   logic             ffv_q, ffv_nxt;
   logic [3:0]       ffidx_q, ffidx_nxt;
   logic             ffen_q, ffen_nxt;
   logic [15:0]      seen_q, seen_nxt;

   logic             exp_f;
   logic             mismatch;
   logic [15:0]      seen_upd;

   // Expected value and mask update are derived from the captured vector, never from the
   // live inputs, so a stimulus that changes early cannot corrupt the check.
   assign exp_f    = vec_q[4] ? EXPECTED[vec_q[3:0]] : DIS_VAL;
   assign mismatch = (f_q != exp_f);
   assign seen_upd = vec_q[4] ? (seen_q | (16'h0001 << vec_q[3:0])) : seen_q;

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec_q;
      cnt_nxt   = cnt_q;
      f_nxt     = f_q;
      err_nxt   = err_q;
      chk_nxt   = chk_q;
      ffv_nxt   = ffv_q;
      ffidx_nxt = ffidx_q;
      ffen_nxt  = ffen_q;
      seen_nxt  = seen_q;

      if (start) begin
         // start wins over a same-cycle handshake and aborts any vector in flight
         state_nxt = S_ARMED;
         err_nxt   = '0;
         chk_nxt   = '0;
         ffv_nxt   = 1'b0;
         ffidx_nxt = 4'd0;
         ffen_nxt  = 1'b0;
         seen_nxt  = 16'h0000;
      end else begin
         case (state)
            S_ARMED: begin
               if (vec_valid) begin
                  vec_nxt   = {EN, a, b, c, d};
                  cnt_nxt   = SETTLE_LD;
                  state_nxt = S_SETTLING;
               end
            end
            S_SETTLING: begin
               if (cnt_q == 4'd0) begin
                  f_nxt     = f;            // f sampled at acceptance edge + SETTLE
                  state_nxt = S_SAMPLE;
               end else begin
                  cnt_nxt = cnt_q - 4'd1;
               end
            end
            S_SAMPLE: begin
               if (mismatch) begin
                  if (err_q != CNT_MAX) err_nxt = err_q + 1'b1;
                  if (!ffv_q) begin
                     ffv_nxt   = 1'b1;
                     ffidx_nxt = vec_q[3:0];
                     ffen_nxt  = vec_q[4];
                  end
               end
               if (chk_q != CNT_MAX) chk_nxt = chk_q + 1'b1;
               seen_nxt  = seen_upd;
               state_nxt = (seen_upd == 16'hFFFF) ? S_DONE : S_ARMED;
            end
            default: ;                      // IDLE and DONE wait for start
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         vec_q   <= 5'd0;
         cnt_q   <= 4'd0;
         f_q     <= 1'b0;
         err_q   <= '0;
         chk_q   <= '0;
         ffv_q   <= 1'b0;
         ffidx_q <= 4'd0;
         ffen_q  <= 1'b0;
         seen_q  <= 16'h0000;
      end else begin
         state   <= state_nxt;
         vec_q   <= vec_nxt;
         cnt_q   <= cnt_nxt;
         f_q     <= f_nxt;
         err_q   <= err_nxt;
         chk_q   <= chk_nxt;
         ffv_q   <= ffv_nxt;
         ffidx_q <= ffidx_nxt;
         ffen_q  <= ffen_nxt;
         seen_q  <= seen_nxt;
      end
   end

   assign vec_ready        = (state == S_ARMED);
   assign done             = (state == S_DONE);
   assign pass             = done && (err_q == '0);
   assign err_count        = err_q;
   assign chk_count        = chk_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_idx   = ffidx_q;
   assign first_fail_en    = ffen_q;
   assign seen_mask        = seen_q;

endmodule
